// File: rtl/mbs_muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// mbs_muldiv_unit_pkg
// Shared definitions for the MBScore multiply/divide unit:
//   - MD_OP_* operation codes (3-bit) and MD_OP_WIDTH
//   - md_state_e : FSM state encoding (IDLE / RUN / FIN)
//   - helpers that classify an op code
// ---------------------------------------------------------------------------
package mbs_muldiv_unit_pkg;

    localparam int MD_OP_WIDTH = 3;

    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULT  = 3'b000;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULTU = 3'b001;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV   = 3'b010;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIVU  = 3'b011;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MTHI  = 3'b100;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_RUN  = 2'd1,
        MD_ST_FIN  = 2'd2
    } md_state_e;

    // MULT/MULTU/DIV/DIVU all have op[2]=0 and take the iterative path.
    function automatic logic md_op_is_iter(input logic [MD_OP_WIDTH-1:0] op);
        return ~op[2];
    endfunction

    function automatic logic md_op_is_signed(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

    function automatic logic md_op_is_div(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/mbs_muldiv_step.sv
// ---------------------------------------------------------------------------
// mbs_muldiv_step
// One combinational radix-2 iteration on the {acc, mq} working pair.
//   div_mode_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i/o    : multiply: running upper product half; divide: partial remainder
//   mq_i/o     : multiply: multiplier shifting out / product low half shifting in;
//                divide: dividend shifting out / quotient shifting in
//   opnd_i     : multiplicand (multiply) or divisor (divide) magnitude
// ---------------------------------------------------------------------------
module mbs_muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  div_mode_i,
    input  logic [DATA_WIDTH-1:0] acc_i,
    input  logic [DATA_WIDTH-1:0] mq_i,
    input  logic [DATA_WIDTH-1:0] opnd_i,
    output logic [DATA_WIDTH-1:0] acc_o,
    output logic [DATA_WIDTH-1:0] mq_o
);

    logic [DATA_WIDTH:0] add_sum;
    logic [DATA_WIDTH:0] sub_shift;
    logic [DATA_WIDTH:0] sub_diff;
    logic                sub_ge;

    always_comb begin
        add_sum   = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
        sub_shift = {acc_i, mq_i[DATA_WIDTH-1]};
        sub_diff  = sub_shift - {1'b0, opnd_i};
        // The partial remainder is always below the divisor, so the shifted
        // value is below 2*divisor and bit DATA_WIDTH of the difference is a
        // clean borrow flag.
        sub_ge    = ~sub_diff[DATA_WIDTH];

        if (div_mode_i) begin
            acc_o = sub_ge ? sub_diff[DATA_WIDTH-1:0] : sub_shift[DATA_WIDTH-1:0];
            mq_o  = {mq_i[DATA_WIDTH-2:0], sub_ge};
        end else begin
            // The add carry becomes the new top bit; the sum LSB moves into mq.
            acc_o = add_sum[DATA_WIDTH:1];
            mq_o  = {add_sum[0], mq_i[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mbs_muldiv_unit.sv
// ---------------------------------------------------------------------------
// mbs_muldiv_unit
// Iterative multiply/divide unit owning the HI/LO registers.
//   clk, rst (async, active-low)
//   start, op, src_a, src_b : request; sampled in IDLE only
//   cancel                  : pipeline flush, aborts RUN/FIN without writing
//   busy                    : iterative op in RUN; pipeline stalls on it
//   done                    : one-cycle pulse when hi/lo were just written
//   hi, lo                  : architectural HI/LO
//   div_by_zero             : set by DIV/DIVU with src_b=0, cleared on next
//                             iterative start
//   dbg_state               : current FSM state, for observation only
//
// Handshake: a request is a one-cycle start with op/src_a/src_b valid in the
// same cycle; it is taken only while the FSM is IDLE (busy=0 and not in the
// FIN write-back cycle). Requesters wait for done before issuing the next
// muldiv or reading hi/lo. start in any other state is dropped.
// ---------------------------------------------------------------------------
module mbs_muldiv_unit
    import mbs_muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [MD_OP_WIDTH-1:0] op,
    input  logic [DATA_WIDTH-1:0]  src_a,
    input  logic [DATA_WIDTH-1:0]  src_b,
    input  logic                   cancel,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  hi,
    output logic [DATA_WIDTH-1:0]  lo,
    output logic                   div_by_zero,
    output logic [1:0]             dbg_state
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    md_state_e             state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] mq_q;
    logic [DATA_WIDTH-1:0] opnd_q;
    logic                  is_div_q;
    logic                  neg_q;      // product / quotient must be negated
    logic                  rem_neg_q;  // remainder takes the dividend's sign
    logic                  dz_q;       // divide-by-zero short path in flight
    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  dbz_q;

    // Request decode
    logic                  op_signed;
    logic                  op_div;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] mag_a;
    logic [DATA_WIDTH-1:0] mag_b;

    always_comb begin
        op_signed = md_op_is_signed(op);
        op_div    = md_op_is_div(op);
        a_neg     = op_signed & src_a[DATA_WIDTH-1];
        b_neg     = op_signed & src_b[DATA_WIDTH-1];
        // |MIN| wraps to MIN, which read as unsigned is the correct magnitude.
        mag_a     = a_neg ? -src_a : src_a;
        mag_b     = b_neg ? -src_b : src_b;
    end

    logic [DATA_WIDTH-1:0] step_acc;
    logic [DATA_WIDTH-1:0] step_mq;

    mbs_muldiv_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .div_mode_i (is_div_q),
        .acc_i      (acc_q),
        .mq_i       (mq_q),
        .opnd_i     (opnd_q),
        .acc_o      (step_acc),
        .mq_o       (step_mq)
    );

    // Sign correction for the FIN write-back
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   fin_hi;
    logic [DATA_WIDTH-1:0]   fin_lo;

    always_comb begin
        prod_fix = neg_q ? -{acc_q, mq_q} : {acc_q, mq_q};
        if (dz_q) begin
            fin_hi = acc_q;
            fin_lo = mq_q;
        end else if (is_div_q) begin
            // MIN / -1 naturally yields quotient MIN and remainder 0 here.
            fin_hi = rem_neg_q ? -acc_q : acc_q;
            fin_lo = neg_q     ? -mq_q  : mq_q;
        end else begin
            fin_hi = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            fin_lo = prod_fix[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= MD_ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_ST_IDLE: begin
                    if (start) begin
                        if (md_op_is_iter(op)) begin
                            dbz_q    <= 1'b0;
                            cnt_q    <= '0;
                            is_div_q <= op_div;
                            if (op_div && (src_b == '0)) begin
                                // Result is preloaded; FIN just copies it out.
                                dz_q      <= 1'b1;
                                acc_q     <= src_a;
                                mq_q      <= '1;
                                neg_q     <= 1'b0;
                                rem_neg_q <= 1'b0;
                                state_q   <= MD_ST_FIN;
                            end else begin
                                dz_q      <= 1'b0;
                                acc_q     <= '0;
                                mq_q      <= op_div ? mag_a : mag_b;
                                opnd_q    <= op_div ? mag_b : mag_a;
                                neg_q     <= a_neg ^ b_neg;
                                rem_neg_q <= a_neg;
                                busy_q    <= 1'b1;
                                state_q   <= MD_ST_RUN;
                            end
                        end else if (op == MD_OP_MTHI) begin
                            hi_q   <= src_a;
                            done_q <= 1'b1;
                        end else if (op == MD_OP_MTLO) begin
                            lo_q   <= src_a;
                            done_q <= 1'b1;
                        end
                    end
                end
                MD_ST_RUN: begin
                    if (cancel) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= MD_ST_IDLE;
                    end else begin
                        acc_q <= step_acc;
                        mq_q  <= step_mq;
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= MD_ST_FIN;
                        end else begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                MD_ST_FIN: begin
                    state_q <= MD_ST_IDLE;
                    if (!cancel) begin
                        hi_q   <= fin_hi;
                        lo_q   <= fin_lo;
                        dbz_q  <= dz_q;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= MD_ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mbs_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_mbs_muldiv_unit
// Directed bench for mbs_muldiv_unit at DATA_WIDTH=32. Expected hi/lo values
// are hand-computed constants. Latency is counted in rising edges after the
// edge that samples start: 33 for iterative ops, 1 for divide by zero.
// ---------------------------------------------------------------------------
module tb_mbs_muldiv_unit;
    import mbs_muldiv_unit_pkg::*;

    localparam int W = 32;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                   start  = 1'b0;
    logic                   cancel = 1'b0;
    logic [MD_OP_WIDTH-1:0] op     = '0;
    logic [W-1:0]           src_a  = '0;
    logic [W-1:0]           src_b  = '0;
    logic                   busy;
    logic                   done;
    logic [W-1:0]           hi;
    logic [W-1:0]           lo;
    logic                   div_by_zero;
    logic [1:0]             dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    mbs_muldiv_unit #(
        .DATA_WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // Scoreboard check
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and follow it to done. poke_at >= 0 drives a stray
    // DIVU 5/0 request that many edges into the run; it must be dropped.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                          input logic e_dbz, input int e_lat, input int e_busy,
                          input int poke_at);
        int lat;
        int busy_cnt;
        bit got;
        op = o; src_a = a; src_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0; busy_cnt = 0; got = 1'b0;
        if (busy) busy_cnt++;
        while (!got && lat < 200) begin
            if (lat == poke_at) begin
                start = 1'b1; op = MD_OP_DIVU; src_a = 32'd5; src_b = 32'd0;
            end
            tick();
            start = 1'b0;
            lat++;
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
        end
        check({tag, "_done"}, got, 1'b1);
        check({tag, "_lat"}, lat, e_lat);
        check({tag, "_busy_cycles"}, busy_cnt, e_busy);
        check({tag, "_hi"}, hi, e_hi);
        check({tag, "_lo"}, lo, e_lo);
        check({tag, "_dbz"}, div_by_zero, e_dbz);
        tick();
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    // Count done pulses over n cycles
    task automatic watch_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;

        // Reset state
        #12;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dbz", div_by_zero, 1'b0);
        check("rst_state", dbg_state, MD_ST_IDLE);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Multiply
        run_op("mult_neg",   MD_OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 32, -1);
        run_op("multu_2",    MD_OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0, 33, 32, -1);
        run_op("multu_max",  MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 32, -1);
        run_op("mult_m1m1",  MD_OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33, 32, -1);
        run_op("mult_minsq", MD_OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 32, -1);

        // Divide
        run_op("div_m7_2",   MD_OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 32, -1);
        run_op("div_ovf",    MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 32, -1);
        run_op("div_7_m2",   MD_OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 32, -1);
        run_op("divu_dz",    MD_OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 1,  0,  -1);
        run_op("divu_100_7", MD_OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 33, 32, -1);
        run_op("div_dz_neg", MD_OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1,  0,  -1);

        // start while busy is dropped
        run_op("mult_poke",  MD_OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 32, 5);

        // MTHI then MTLO back to back
        op = MD_OP_MTHI; src_a = 32'h12345678; start = 1'b1;
        tick();
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_lo", lo, 32'hFFFFFFEB);
        check("mthi_done", done, 1'b1);
        check("mthi_busy", busy, 1'b0);
        op = MD_OP_MTLO; src_a = 32'h9ABCDEF0;
        tick();
        start = 1'b0;
        check("mtlo_lo", lo, 32'h9ABCDEF0);
        check("mtlo_hi", hi, 32'h12345678);
        check("mtlo_done", done, 1'b1);
        check("mtlo_busy", busy, 1'b0);
        tick();
        check("mt_done_end", done, 1'b0);

        // Cancel mid-run together with a new start
        op = MD_OP_MULT; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        check("cancel_busy_run", busy, 1'b1);
        repeat (9) tick();
        cancel = 1'b1; start = 1'b1; op = MD_OP_MULTU; src_a = 32'd3; src_b = 32'd3;
        tick();
        cancel = 1'b0; start = 1'b0;
        check("cancel_busy", busy, 1'b0);
        check("cancel_done", done, 1'b0);
        check("cancel_state", dbg_state, MD_ST_IDLE);
        watch_done(40, dcnt);
        check("cancel_no_done", dcnt, 0);
        check("cancel_hi", hi, 32'h12345678);
        check("cancel_lo", lo, 32'h9ABCDEF0);

        // Reserved op: no effect
        op = 3'b110; src_a = 32'hDEADBEEF; start = 1'b1;
        tick();
        start = 1'b0;
        check("rsvd_busy", busy, 1'b0);
        watch_done(4, dcnt);
        check("rsvd_no_done", dcnt, 0);
        check("rsvd_hi", hi, 32'h12345678);
        check("rsvd_lo", lo, 32'h9ABCDEF0);

        // Async reset mid-operation
        op = MD_OP_MULT; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2;
        rst = 1'b0;
        #1;
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_dbz", div_by_zero, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        watch_done(40, dcnt);
        check("arst_no_done", dcnt, 0);
        check("arst_hi_kept", hi, 32'h0);

        // Recovery after reset
        run_op("post_rst", MD_OP_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 33, 32, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
